// File: rtl/mpaddsub_iter.sv
// Iterative multi-precision adder/subtractor: one CHUNK-bit limb per cycle through a
// single carry-chained adder, with a busy/done handshake and a WIDTH+1-bit result.
module mpaddsub_iter #(
  parameter int WIDTH = 1027,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             subtract,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   result,
  output logic             busy,
  output logic             done
);

  localparam int N  = (WIDTH + CHUNK - 1) / CHUNK;
  localparam int NC = N * CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_r;
  logic [NC-1:0]    a_r;
  logic [NC-1:0]    b_r;
  logic [NC-1:0]    buf_r;
  logic [CW-1:0]    cnt_r;
  logic             carry_r;

  logic [WIDTH-1:0] b_sel_s;
  logic [CHUNK:0]   sum_s;
  logic [NC-1:0]    buf_next_s;
  logic [WIDTH:0]   result_next_s;
  logic             last_s;

  // Limb adder and the next buffer image; operands and buffer shift one limb per cycle.
  always_comb begin
    b_sel_s       = subtract ? ~in_b : in_b;
    sum_s         = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_r};
    buf_next_s    = buf_r >> CHUNK;
    buf_next_s[NC-1 -: CHUNK] = sum_s[CHUNK-1:0];
    // Bit WIDTH lands inside the top limb when padded, or is the final carry otherwise.
    result_next_s = (WIDTH + 1)'({sum_s[CHUNK], buf_next_s});
    last_s        = (cnt_r == CW'(N - 1));
  end

  // Control FSM with capture, limb iteration and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      buf_r   <= '0;
      cnt_r   <= '0;
      carry_r <= 1'b0;
      result  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_r     <= NC'(in_a);
            b_r     <= NC'(b_sel_s);
            cnt_r   <= '0;
            carry_r <= subtract;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          a_r     <= a_r >> CHUNK;
          b_r     <= b_r >> CHUNK;
          buf_r   <= buf_next_s;
          carry_r <= sum_s[CHUNK];
          cnt_r   <= cnt_r + CW'(1);
          if (last_s) begin
            result  <= result_next_s;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_r <= IDLE;
          end else begin
            done    <= 1'b0;
            busy    <= 1'b1;
            state_r <= RUN;
          end
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpaddsub_iter.sv
// Scoreboard bench for mpaddsub_iter: three parametrisations share one clock and reset;
// stimulus pushes expected results/done edges, a negedge monitor pops and compares.
module tb_mpaddsub_iter;

  localparam int ND = 3;
  typedef logic [1028:0] big_t;
  typedef struct {
    big_t res;
    int   done_edge;
  } exp_t;

  int ws[ND] = '{1027, 130, 128};
  int ns[ND] = '{17, 5, 4};

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  logic         start_v[ND];
  logic         sub_v[ND];
  logic [1026:0] a_v[ND];
  logic [1026:0] b_v[ND];

  logic [1027:0] r0;
  logic [130:0]  r1;
  logic [128:0]  r2;
  logic bz0, bz1, bz2, dn0, dn1, dn2;
  big_t res_a[ND];
  logic busy_a[ND];
  logic done_a[ND];

  exp_t q[ND][$];
  big_t held[ND];

  assign res_a[0] = big_t'(r0);
  assign res_a[1] = big_t'(r1);
  assign res_a[2] = big_t'(r2);
  assign busy_a[0] = bz0;
  assign busy_a[1] = bz1;
  assign busy_a[2] = bz2;
  assign done_a[0] = dn0;
  assign done_a[1] = dn1;
  assign done_a[2] = dn2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mpaddsub_iter #(.WIDTH(1027), .CHUNK(64)) dut0 (
    .clk(clk), .reset(reset), .start(start_v[0]), .subtract(sub_v[0]),
    .in_a(a_v[0]), .in_b(b_v[0]), .result(r0), .busy(bz0), .done(dn0));
  mpaddsub_iter #(.WIDTH(130), .CHUNK(32)) dut1 (
    .clk(clk), .reset(reset), .start(start_v[1]), .subtract(sub_v[1]),
    .in_a(a_v[1][129:0]), .in_b(b_v[1][129:0]), .result(r1), .busy(bz1), .done(dn1));
  mpaddsub_iter #(.WIDTH(128), .CHUNK(32)) dut2 (
    .clk(clk), .reset(reset), .start(start_v[2]), .subtract(sub_v[2]),
    .in_a(a_v[2][127:0]), .in_b(b_v[2][127:0]), .result(r2), .busy(bz2), .done(dn2));

  // Reference: plain modular add, or difference with an a>=b flag in bit w.
  function automatic big_t ref_model(big_t a, big_t b, bit sub, int w);
    big_t mask;
    big_t am;
    big_t bm;
    mask = (big_t'(1) << w) - big_t'(1);
    am = a & mask;
    bm = b & mask;
    if (sub) return ((am - bm) & mask) | (big_t'(am >= bm) << w);
    return am + bm;
  endfunction

  function automatic big_t rnd();
    logic [1055:0] t;
    for (int i = 0; i < 33; i++) t[i*32 +: 32] = $urandom;
    return big_t'(t);
  endfunction

  task automatic check(string name, big_t act, big_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: per DUT compares busy/done every cycle, pops the scoreboard on done.
  always @(negedge clk) begin : mon
    bit eb;
    bit ed;
    for (int i = 0; i < ND; i++) begin
      eb = 1'b0;
      ed = 1'b0;
      if (q[i].size() > 0) begin
        eb = (cyc >= q[i][0].done_edge - ns[i]) && (cyc < q[i][0].done_edge);
        ed = (cyc == q[i][0].done_edge);
      end
      check($sformatf("busy%0d", i), big_t'(busy_a[i]), big_t'(eb));
      check($sformatf("done%0d", i), big_t'(done_a[i]), big_t'(ed));
      if (ed) begin
        check($sformatf("result%0d", i), res_a[i], q[i][0].res);
        held[i] = q[i][0].res;
        void'(q[i].pop_front());
      end else begin
        check($sformatf("hold%0d", i), res_a[i], held[i]);
        if (q[i].size() > 0 && cyc > q[i][0].done_edge) void'(q[i].pop_front());
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+2.
  task automatic drive(int id, bit st, big_t a, big_t b, bit sub);
    exp_t e;
    start_v[id] = st;
    a_v[id] = a[1026:0];
    b_v[id] = b[1026:0];
    sub_v[id] = sub;
    if (st && (q[id].size() == 0 || q[id][q[id].size()-1].done_edge <= cyc)) begin
      e.res = ref_model(a, b, sub, ws[id]);
      e.done_edge = cyc + 1 + ns[id];
      q[id].push_back(e);
    end
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(int id);
    int k;
    k = 0;
    while (q[id].size() > 0 && k < 2 * ns[id] + 6) begin
      drive(id, 1'b0, rnd(), rnd(), 1'($urandom));
      k++;
    end
    checks++;
    if (q[id].size() > 0) begin
      errors++;
      $display("FAIL timeout%0d: %0d results still pending, required 0", id, q[id].size());
      q[id].delete();
    end
  endtask

  task automatic op(int id, big_t a, big_t b, bit sub);
    drive(id, 1'b1, a, b, sub);
    wait_idle(id);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    big_t all1027, all130, all128, pa, pb;
    for (int i = 0; i < ND; i++) begin
      start_v[i] = 1'b0;
      sub_v[i] = 1'b0;
      a_v[i] = '0;
      b_v[i] = '0;
      held[i] = '0;
    end
    all1027 = (big_t'(1) << 1027) - big_t'(1);
    all130  = (big_t'(1) << 130) - big_t'(1);
    all128  = (big_t'(1) << 128) - big_t'(1);

    repeat (3) @(posedge clk);
    #2;
    check("reset_result0", res_a[0], big_t'(0));
    reset = 1'b0;

    op(0, big_t'(5), big_t'(7), 1'b0);
    op(0, all1027, all1027, 1'b0);
    op(0, big_t'(1) << 64, big_t'(1), 1'b1);
    op(0, big_t'(1), big_t'(2), 1'b1);
    op(0, big_t'(12345), big_t'(12345), 1'b1);

    // A second start three cycles into RUN must be ignored.
    drive(0, 1'b1, rnd(), rnd(), 1'b0);
    repeat (2) drive(0, 1'b0, rnd(), rnd(), 1'b0);
    drive(0, 1'b1, rnd(), rnd(), 1'b1);
    wait_idle(0);

    // Start held high through the done cycle: second capture right after completion.
    drive(0, 1'b1, rnd(), rnd(), 1'b1);
    pa = rnd();
    pb = rnd();
    repeat (ns[0] + 1) drive(0, 1'b1, pa, pb, 1'b0);
    wait_idle(0);

    // Reset at limb 8 aborts the operation without a done pulse.
    drive(0, 1'b1, rnd(), rnd(), 1'b0);
    repeat (8) drive(0, 1'b0, rnd(), rnd(), 1'b0);
    reset = 1'b1;
    #1;
    check("rst_busy0", big_t'(bz0), big_t'(0));
    check("rst_done0", big_t'(dn0), big_t'(0));
    check("rst_result0", res_a[0], big_t'(0));
    for (int i = 0; i < ND; i++) begin
      q[i].delete();
      held[i] = '0;
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (ns[0] + 4) drive(0, 1'b0, rnd(), rnd(), 1'b0);
    op(0, big_t'(1000), big_t'(1), 1'b1);

    for (int i = 0; i < 6; i++) op(0, rnd(), rnd(), 1'($urandom));

    op(1, all130, big_t'(1), 1'b0);
    op(1, big_t'(3), big_t'(9), 1'b1);
    op(1, all130, all130, 1'b1);
    for (int i = 0; i < 25; i++) begin
      pa = rnd();
      op(1, pa, (i % 5 == 0) ? pa : rnd(), 1'($urandom));
    end

    op(2, all128, all128, 1'b0);
    op(2, big_t'(0), big_t'(1), 1'b1);
    for (int i = 0; i < 15; i++) op(2, rnd(), rnd(), 1'($urandom));

    repeat (3) drive(0, 1'b0, big_t'(0), big_t'(0), 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
